breath_pwm_multi: RTL and testbench
===================================

Name: breath_pwm_multi

Overview:
- Multi-channel "breathing" LED PWM generator: a shared PWM counter, a programmable step prescaler and a 64-entry sine-shaped brightness table drive CHANNELS outputs, each offset in phase.
- Adds off, steady-level and single-breath modes, plus glitch-free duty updates on PWM period boundaries.
- Sits between board switches/registers and LED pins; one instance drives an RGB or LED bar group.

Parameters:
- PWM_WIDTH, 6, PWM counter width; period = 2^PWM_WIDTH clocks; legal values 6..12.
- CHANNELS, 3, number of pulse outputs; legal values 1..8.
- PRESCALE_W, 8, width of the step_div input.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  output gate; 0 forces all pulses low, counters keep running.
- mode  in  2  00 off, 01 steady, 10 breathe continuous, 11 single breath.
- step_div  in  PRESCALE_W  PWM periods per table step, minus 1.
- level  in  PWM_WIDTH  duty used in steady mode.
- pulse  out  CHANNELS  PWM outputs, registered.
- breath_done  out  1  one-cycle strobe when the base index wraps 63->0.
- base_idx  out  6  current base table index, for debug and verification.

Behaviour:
- Clock and reset: one clock (sysclk); rst is synchronous and active-high.
- Reset values:
  - pwm_cnt=0, pre_cnt=0, base_idx=0.
  - All latched duties = 0, pulse = 0, breath_done = 0, single-breath stopped flag = 0.
- PWM counter: pwm_cnt increments every clock and wraps at 2^PWM_WIDTH-1 -> 0.
  - period_end = (pwm_cnt == all ones).
- Prescaler: on period_end, if pre_cnt == step_div then pre_cnt <= 0 and step strobe fires; else pre_cnt++.
  - step_div = 0 gives one step per PWM period.
  - step_div changed mid-count: the comparison uses the live value. If pre_cnt > step_div, pre_cnt counts up to its maximum, wraps to 0 and then matches.
- Base index:
  - On step, base_idx <= base_idx + 1, modulo 64, in modes 10 and 11 (unless stopped).
  - In modes 00 and 01, base_idx holds.
  - breath_done pulses for one cycle on the step where base_idx goes 63 -> 0, in mode 10 or 11.
- Single breath (mode 11):
  - After the 63->0 wrap, set stopped; base_idx holds at 0 and all duties evaluate 0.
  - stopped clears when mode leaves 11 or on rst.
  - Re-entering mode 11 restarts from the current base_idx.
- Channel index: idx[k] = base_idx + (k*64)/CHANNELS, modulo 64, integer division.
- Table: 6-bit sine-squared shape, symmetric about entries 31/32.
  - Required entries: 0->0, 2->1, 8->10, 16->33, 24->55, 30..33->63, 40->53, 48->30, 56->8, 62,63->0.
  - Entry e and entry 63-e are equal.
- Duty scaling: table value is left-shifted by (PWM_WIDTH-6), zero fill.
- Duty latch: duty[k] is sampled only on period_end and takes effect from pwm_cnt=0.
  - Mode 00: 0.
  - Mode 01: level.
  - Mode 10/11: scaled table value for idx[k]; 0 when stopped.
  - Mode, level and index changes therefore never glitch mid-period.
- Output: pulse[k] <= enable & (pwm_cnt < duty[k]), one clock latency from pwm_cnt.
  - Duty 0 gives a constant low output.
  - Maximum duty gives 2^PWM_WIDTH-1 high clocks out of 2^PWM_WIDTH.
- Simultaneous events:
  - Step and period_end coincide by construction. The duty latched at that edge uses the pre-increment base_idx, so the new index appears one period later.
  - rst has priority over everything.
- Reset mid-operation: all state returns to the reset values on the next edge; pulse is low on the following cycle.

Decomposition:
- Shared package (breath_pkg):
  - Mode encodings MODE_OFF/STEADY/BREATHE/SINGLE.
  - Table depth constant 64 and table index width 6.
- One sub-module, breath_lut: purely combinational 6-bit index -> 6-bit value, instantiated once per channel.

Test Plan:
- rst high for 3 cycles, then released, mode=10, step_div=0, CHANNELS=3, enable=1 -> base_idx increments every 64 clocks. Channel phase offsets are 0, 21 and 42 from base_idx. At base_idx=16, ch0 shows 33 high clocks per 64-clock period.
- mode=01, level=20, changed to level=40 while pwm_cnt=10 -> the current period stays at 20 high clocks; the next period shows 40.
- mode=11, step_div=1 -> breath_done fires once after 64 steps (8192 clocks). Afterwards base_idx stays 0 and all pulses stay low. Switching to mode=10 resumes stepping.
- enable=0 for 200 clocks in mode 10 -> pulse stays 0. base_idx keeps advancing, so after re-enable the brightness is not where it stopped.
- PWM_WIDTH=8, mode=10, base_idx=31 -> duty = 63<<2 = 252, i.e. 252 high clocks of 256.
- rst asserted mid-period with pulse high -> pulse=0 the cycle after, and pwm_cnt, pre_cnt and base_idx are all 0.

Source files
------------

// File: rtl/breath_pkg.sv
`default_nettype none
// ============================================================================
// breath_pkg : mode encodings and brightness-table geometry
// Rev 1.0
// ============================================================================
package breath_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_STEADY  = 2'b01,
      MODE_BREATHE = 2'b10,
      MODE_SINGLE  = 2'b11
   } mode_e;

   localparam int TABLE_DEPTH = 64;
   localparam int IDX_W       = 6;

endpackage
`default_nettype wire

// File: rtl/breath_lut.sv
`default_nettype none
// ============================================================================
// breath_lut : 64-entry sine-squared brightness table, 6-bit in, 6-bit out
// Rev 1.0
// ============================================================================
module breath_lut
   import breath_pkg::*;
(
   input  logic [IDX_W-1:0] i_idx,
   output logic [5:0]       o_val
);

   // Upper half mirrors the lower half: entry e equals entry 63-e.
   logic [4:0] w_addr;
   assign w_addr = i_idx[5] ? ~i_idx[4:0] : i_idx[4:0];

   always_comb begin
      o_val = 6'd0;
      case (w_addr)
         5'd0:  o_val = 6'd0;
         5'd1:  o_val = 6'd0;
         5'd2:  o_val = 6'd1;
         5'd3:  o_val = 6'd2;
         5'd4:  o_val = 6'd3;
         5'd5:  o_val = 6'd4;
         5'd6:  o_val = 6'd6;
         5'd7:  o_val = 6'd8;
         5'd8:  o_val = 6'd10;
         5'd9:  o_val = 6'd13;
         5'd10: o_val = 6'd15;
         5'd11: o_val = 6'd18;
         5'd12: o_val = 6'd21;
         5'd13: o_val = 6'd24;
         5'd14: o_val = 6'd27;
         5'd15: o_val = 6'd30;
         5'd16: o_val = 6'd33;
         5'd17: o_val = 6'd36;
         5'd18: o_val = 6'd39;
         5'd19: o_val = 6'd42;
         5'd20: o_val = 6'd45;
         5'd21: o_val = 6'd48;
         5'd22: o_val = 6'd50;
         5'd23: o_val = 6'd53;
         5'd24: o_val = 6'd55;
         5'd25: o_val = 6'd57;
         5'd26: o_val = 6'd59;
         5'd27: o_val = 6'd60;
         5'd28: o_val = 6'd61;
         5'd29: o_val = 6'd62;
         5'd30: o_val = 6'd63;
         5'd31: o_val = 6'd63;
         default: o_val = 6'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/breath_pwm_multi.sv
`default_nettype none
// ============================================================================
// breath_pwm_multi : multi-channel breathing LED PWM with phase-offset channels
// Rev 1.0
// ============================================================================
module breath_pwm_multi
   import breath_pkg::*;
#(
   parameter int PWM_WIDTH  = 6,
   parameter int CHANNELS   = 3,
   parameter int PRESCALE_W = 8
) (
   input  logic                  sysclk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic [PRESCALE_W-1:0] step_div,
   input  logic [PWM_WIDTH-1:0]  level,
   output logic [CHANNELS-1:0]   pulse,
   output logic                  breath_done,
   output logic [IDX_W-1:0]      base_idx
);

   logic [PWM_WIDTH-1:0]  r_pwm_cnt;
   logic [PRESCALE_W-1:0] r_pre_cnt;
   logic [IDX_W-1:0]      r_base_idx;
   logic                  r_stopped;
   logic                  r_breath_done;
   logic [CHANNELS-1:0]   r_pulse;
   logic [CHANNELS-1:0]   w_pulse_next;

   logic w_period_end;
   logic w_step;
   logic w_running;
   logic w_advance;
   logic w_wrap;

   assign w_period_end = &r_pwm_cnt;
   assign w_step       = w_period_end && (r_pre_cnt == step_div);
   assign w_running    = (mode == MODE_BREATHE) || ((mode == MODE_SINGLE) && !r_stopped);
   assign w_advance    = w_step && w_running;
   assign w_wrap       = w_advance && (&r_base_idx);

   // Prescaler wraps naturally when step_div is lowered below the live count.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         r_pwm_cnt     <= '0;
         r_pre_cnt     <= '0;
         r_base_idx    <= '0;
         r_stopped     <= 1'b0;
         r_breath_done <= 1'b0;
         r_pulse       <= '0;
      end else begin
         r_pwm_cnt     <= r_pwm_cnt + PWM_WIDTH'(1);
         r_breath_done <= w_wrap;
         r_pulse       <= w_pulse_next;
         if (w_period_end) begin
            if (r_pre_cnt == step_div) r_pre_cnt <= '0;
            else                       r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
         end
         if (w_advance) r_base_idx <= r_base_idx + IDX_W'(1);
         if (mode != MODE_SINGLE) r_stopped <= 1'b0;
         else if (w_wrap)         r_stopped <= 1'b1;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      localparam logic [IDX_W-1:0] c_offset = IDX_W'((k * TABLE_DEPTH) / CHANNELS);

      logic [IDX_W-1:0]     w_idx;
      logic [5:0]           w_tbl;
      logic [PWM_WIDTH-1:0] w_scaled;
      logic [PWM_WIDTH-1:0] w_duty_next;
      logic [PWM_WIDTH-1:0] r_duty;

      assign w_idx    = r_base_idx + c_offset;
      assign w_scaled = PWM_WIDTH'(w_tbl) << (PWM_WIDTH - 6);

      breath_lut u_lut (
         .i_idx (w_idx),
         .o_val (w_tbl)
      );

      always_comb begin
         w_duty_next = '0;
         case (mode)
            MODE_STEADY:  w_duty_next = level;
            MODE_BREATHE: w_duty_next = w_scaled;
            MODE_SINGLE:  w_duty_next = r_stopped ? '0 : w_scaled;
            default:      w_duty_next = '0;
         endcase
      end

      // Duty only changes as the counter wraps, so a period is never cut short.
      always_ff @(posedge sysclk) begin
         if (rst)               r_duty <= '0;
         else if (w_period_end) r_duty <= w_duty_next;
      end

      assign w_pulse_next[k] = enable && (r_pwm_cnt < r_duty);
   end

   assign pulse       = r_pulse;
   assign breath_done = r_breath_done;
   assign base_idx    = r_base_idx;

endmodule
`default_nettype wire

// File: tb/tb_breath_pwm_multi.sv
`default_nettype none
// ============================================================================
// tb_breath_pwm_multi : directed, table-driven bench for breath_pwm_multi
// Rev 1.0
// ============================================================================
module tb_breath_pwm_multi;
   import breath_pkg::*;

   logic       sysclk = 1'b0;
   logic       rst = 1'b1, enable = 1'b1;
   logic [1:0] mode = MODE_BREATHE;
   logic [7:0] step_div = 8'd0;
   logic [5:0] level = 6'd0;
   logic [2:0] pulse;
   logic       breath_done;
   logic [5:0] base_idx;

   logic       rst8 = 1'b1, enable8 = 1'b1;
   logic [1:0] mode8 = MODE_BREATHE;
   logic [7:0] step_div8 = 8'd0;
   logic [7:0] level8 = 8'd0;
   logic [2:0] pulse8;
   logic       breath_done8;
   logic [5:0] base_idx8;

   int cyc = 0, cyc8 = 0, done_cnt = 0, done_at = -1;
   int tests = 0, fails = 0;

   typedef struct {
      int m;
      int base;
      int e0;
      int e1;
      int e2;
   } vec_t;
   vec_t tv[10];

   always #5 sysclk = ~sysclk;

   breath_pwm_multi #(.PWM_WIDTH(6), .CHANNELS(3), .PRESCALE_W(8)) u_dut (
      .sysclk(sysclk), .rst(rst), .enable(enable), .mode(mode), .step_div(step_div),
      .level(level), .pulse(pulse), .breath_done(breath_done), .base_idx(base_idx)
   );

   breath_pwm_multi #(.PWM_WIDTH(8), .CHANNELS(3), .PRESCALE_W(8)) u_dut8 (
      .sysclk(sysclk), .rst(rst8), .enable(enable8), .mode(mode8), .step_div(step_div8),
      .level(level8), .pulse(pulse8), .breath_done(breath_done8), .base_idx(base_idx8)
   );

   // Clocks since reset release; equals the expected PWM counter value.
   always @(posedge sysclk) begin
      if (rst) cyc <= 0; else cyc <= cyc + 1;
      if (rst8) cyc8 <= 0; else cyc8 <= cyc8 + 1;
   end

   always @(negedge sysclk) begin
      if (rst) begin
         done_cnt <= 0;
         done_at  <= -1;
      end else if (breath_done) begin
         if (done_cnt == 0) done_at <= cyc;
         done_cnt <= done_cnt + 1;
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset(input bit w8);
      @(negedge sysclk);
      if (w8) rst8 = 1'b1; else rst = 1'b1;
      @(negedge sysclk);
      check(w8 ? "rst pulse8" : "rst pulse", w8 ? int'(pulse8) : int'(pulse), 0);
      check(w8 ? "rst base8" : "rst base", w8 ? int'(base_idx8) : int'(base_idx), 0);
      check(w8 ? "rst done8" : "rst done", w8 ? int'(breath_done8) : int'(breath_done), 0);
      repeat (2) @(negedge sysclk);
      if (w8) rst8 = 1'b0; else rst = 1'b0;
   endtask

   task automatic goto_cyc(input int tgt, input bit w8);
      int g = 0;
      while (((w8 ? cyc8 : cyc) < tgt) && g < 20000) begin
         @(negedge sysclk);
         g++;
      end
      check($sformatf("goto %0d", tgt), w8 ? cyc8 : cyc, tgt);
   endtask

   // Counts high samples per channel over len clocks starting at cycle start.
   task automatic measure(input int start, input int len, input int chg_i,
                          input logic [5:0] chg_lvl, input bit w8,
                          output int h0, output int h1, output int h2);
      logic [2:0] p;
      h0 = 0; h1 = 0; h2 = 0;
      goto_cyc(start, w8);
      for (int i = 0; i < len; i++) begin
         p = w8 ? pulse8 : pulse;
         h0 += int'(p[0]);
         h1 += int'(p[1]);
         h2 += int'(p[2]);
         if (i == chg_i) level = chg_lvl;
         @(negedge sysclk);
      end
   endtask

   initial begin
      int h0, h1, h2, ones;

      // Period m samples the duty latched from table index m-1.
      tv[0] = '{m: 1,  base: 1,  e0: 0,  e1: 48, e2: 48};
      tv[1] = '{m: 9,  base: 9,  e0: 10, e1: 62, e2: 24};
      tv[2] = '{m: 17, base: 17, e0: 33, e1: 59, e2: 4};
      tv[3] = '{m: 25, base: 25, e0: 55, e1: 39, e2: 1};
      tv[4] = '{m: 32, base: 32, e0: 63, e1: 18, e2: 13};
      tv[5] = '{m: 41, base: 41, e0: 53, e1: 1,  e2: 39};
      tv[6] = '{m: 49, base: 49, e0: 30, e1: 4,  e2: 59};
      tv[7] = '{m: 57, base: 57, e0: 8,  e1: 24, e2: 62};
      tv[8] = '{m: 64, base: 0,  e0: 0,  e1: 45, e2: 50};
      tv[9] = '{m: 65, base: 1,  e0: 0,  e1: 48, e2: 48};

      // Continuous breathe, one step per period
      do_reset(1'b0);
      for (int i = 0; i < 10; i++) begin
         goto_cyc(64 * tv[i].m + 1, 1'b0);
         check($sformatf("bre m=%0d base", tv[i].m), int'(base_idx), tv[i].base);
         measure(64 * tv[i].m + 1, 64, -1, 6'd0, 1'b0, h0, h1, h2);
         check($sformatf("bre m=%0d ch0", tv[i].m), h0, tv[i].e0);
         check($sformatf("bre m=%0d ch1", tv[i].m), h1, tv[i].e1);
         check($sformatf("bre m=%0d ch2", tv[i].m), h2, tv[i].e2);
      end

      // Steady level, changed mid-period
      mode = MODE_STEADY; level = 6'd20;
      do_reset(1'b0);
      measure(65, 64, -1, 6'd0, 1'b0, h0, h1, h2);
      check("steady p1 ch0", h0, 20);
      check("steady p1 ch2", h2, 20);
      measure(129, 64, 9, 6'd40, 1'b0, h0, h1, h2);
      check("steady chg ch0", h0, 20);
      check("steady chg ch1", h1, 20);
      measure(193, 64, -1, 6'd0, 1'b0, h0, h1, h2);
      check("steady new ch0", h0, 40);
      check("steady new ch2", h2, 40);

      // Single breath with step_div=1
      mode = MODE_SINGLE; step_div = 8'd1; level = 6'd0;
      do_reset(1'b0);
      goto_cyc(4097, 1'b0);
      check("single mid base", int'(base_idx), 32);
      goto_cyc(8257, 1'b0);
      check("single done count", done_cnt, 1);
      check("single done cycle", done_at, 8192);
      measure(8257, 128, -1, 6'd0, 1'b0, h0, h1, h2);
      check("stopped ch0", h0, 0);
      check("stopped ch1", h1, 0);
      check("stopped ch2", h2, 0);
      check("stopped base", int'(base_idx), 0);
      goto_cyc(8449, 1'b0);
      check("stopped base late", int'(base_idx), 0);
      mode = MODE_BREATHE;
      goto_cyc(8705, 1'b0);
      check("resume base", int'(base_idx), 2);
      check("resume done count", done_cnt, 1);

      // Output gate
      mode = MODE_BREATHE; step_div = 8'd0;
      do_reset(1'b0);
      goto_cyc(64, 1'b0);
      enable = 1'b0;
      ones = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sysclk);
         ones += $countones(pulse);
      end
      check("gated pulses", ones, 0);
      check("gated base", int'(base_idx), 4);
      enable = 1'b1;
      measure(321, 64, -1, 6'd0, 1'b0, h0, h1, h2);
      check("regate ch0", h0, 3);
      check("regate ch1", h1, 57);
      check("regate ch2", h2, 36);

      // Reset mid-period with a pulse high
      step_div = 8'd1;
      do_reset(1'b0);
      goto_cyc(581, 1'b0);
      check("pre-reset ch1 high", int'(pulse[1]), 1);
      do_reset(1'b0);
      goto_cyc(64, 1'b0);
      check("post-reset base @64", int'(base_idx), 0);
      goto_cyc(128, 1'b0);
      check("post-reset base @128", int'(base_idx), 1);

      // 8-bit PWM: index 31 scales to 252 of 256
      do_reset(1'b1);
      goto_cyc(8193, 1'b1);
      check("w8 base", int'(base_idx8), 32);
      measure(8193, 256, -1, 6'd0, 1'b1, h0, h1, h2);
      check("w8 ch0", h0, 252);
      check("w8 ch1", h1, 72);
      check("w8 ch2", h2, 52);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
